// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps a DDS tuning word from a start word up to an inclusive
// stop word in fixed increments. Each word is held for a programmable dwell time.
// The sweep runs either once (one-shot) or repeatedly (wrapping back to the start).
// The configuration is captured when a sweep is accepted, so later changes to the
// cfg_* inputs do not disturb a sweep that is already running.
module dds_sweep_ctrl #(
  parameter int TW_WIDTH    = 32,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   pause,
  input  logic                   cfg_mode,
  input  logic [TW_WIDTH-1:0]    cfg_start_tw,
  input  logic [TW_WIDTH-1:0]    cfg_stop_tw,
  input  logic [TW_WIDTH-1:0]    cfg_step,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  output logic [TW_WIDTH-1:0]    tw_out,
  output logic                   tw_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);

  state_t                 state;
  logic [TW_WIDTH-1:0]    start_tw_r;
  logic [TW_WIDTH-1:0]    stop_tw_r;
  logic [TW_WIDTH-1:0]    step_r;
  logic [DWELL_WIDTH-1:0] dwell_r;
  logic                   mode_r;
  logic [DWELL_WIDTH-1:0] dwell_cnt;

  // The next word is formed one bit wider than the tuning word. A carry out of
  // the top bit therefore compares as larger than any stop word, so a sweep near
  // the top of the range ends instead of wrapping around to a small word.
  logic [TW_WIDTH:0] next_tw;
  logic              past_stop;
  logic              cfg_bad;

  assign next_tw   = {1'b0, tw_out} + {1'b0, step_r};
  assign past_stop = (next_tw > {1'b0, stop_tw_r});
  assign cfg_bad   = (cfg_step == '0) || (cfg_stop_tw < cfg_start_tw);

  // Sweep state machine with registered outputs.
  // Priority inside RUN: abort first, then pause, then dwell expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tw_out     <= '0;
      tw_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      dwell_cnt  <= '0;
      start_tw_r <= '0;
      stop_tw_r  <= '0;
      step_r     <= '0;
      dwell_r    <= '0;
      mode_r     <= 1'b0;
    end else begin
      tw_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (cfg_bad) begin
              // Rejected start: stay idle and keep the old tuning word.
              err <= 1'b1;
            end else begin
              start_tw_r <= cfg_start_tw;
              stop_tw_r  <= cfg_stop_tw;
              step_r     <= cfg_step;
              dwell_r    <= cfg_dwell;
              mode_r     <= cfg_mode;
              tw_out     <= cfg_start_tw;
              tw_valid   <= 1'b1;
              dwell_cnt  <= cfg_dwell;
              busy       <= 1'b1;
              state      <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (pause) begin
            // Frozen: the dwell count and the tuning word both hold.
          end else if (dwell_cnt != '0) begin
            dwell_cnt <= dwell_cnt - DWELL_ONE;
          end else if (!past_stop) begin
            tw_out    <= next_tw[TW_WIDTH-1:0];
            tw_valid  <= 1'b1;
            dwell_cnt <= dwell_r;
          end else if (mode_r) begin
            tw_out    <= start_tw_r;
            tw_valid  <= 1'b1;
            dwell_cnt <= dwell_r;
          end else begin
            // One-shot sweep is finished; tw_out keeps the last word.
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          // done was raised on entry to this state and clears here.
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Testbench for dds_sweep_ctrl. It applies a table of directed vectors, a few
// hand-written corner sequences, and then random stimulus. Every cycle the outputs
// are compared against a reference model. The model expands each sweep into a
// queue of per-cycle words and walks an index through that queue.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, abort = 1'b0, pause = 1'b0, cfg_mode = 1'b0;
  logic [31:0] cfg_start_tw = '0, cfg_stop_tw = '0, cfg_step = '0;
  logic [15:0] cfg_dwell = '0;
  logic [31:0] tw_out;
  logic        tw_valid, busy, done, err;

  int total = 0;
  int bad = 0;

  dds_sweep_ctrl #(.TW_WIDTH(32), .DWELL_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pause(pause),
    .cfg_mode(cfg_mode), .cfg_start_tw(cfg_start_tw), .cfg_stop_tw(cfg_stop_tw),
    .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .tw_out(tw_out),
    .tw_valid(tw_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_state;   // 0 idle, 1 sweeping, 2 done cycle
  logic [31:0] m_tw;
  bit          m_valid, m_busy, m_done, m_err, m_mode;
  int          m_dwell;
  longint      q[$];      // one entry per output cycle of a full pass
  int          p;

  function automatic void model_reset();
    m_state = 0; m_tw = '0; m_valid = 0; m_busy = 0; m_done = 0; m_err = 0;
    p = 0; q.delete();
  endfunction

  function automatic void model_edge();
    m_valid = 0; m_done = 0; m_err = 0;
    case (m_state)
      0: if (start && !abort) begin
        if (cfg_step == 0 || cfg_stop_tw < cfg_start_tw) m_err = 1;
        else begin
          q.delete();
          for (longint w = longint'(cfg_start_tw); w <= longint'(cfg_stop_tw); w += longint'(cfg_step))
            repeat (int'(cfg_dwell) + 1) q.push_back(w);
          m_dwell = int'(cfg_dwell); m_mode = cfg_mode;
          p = 0; m_tw = 32'(q[0]); m_valid = 1; m_busy = 1; m_state = 1;
        end
      end
      1: if (abort) begin
        m_state = 0; m_busy = 0;
      end else if (!pause) begin
        p++;
        if (p == q.size()) begin
          if (m_mode) begin p = 0; m_tw = 32'(q[0]); m_valid = 1; end
          else begin m_state = 2; m_done = 1; m_busy = 0; end
        end else begin
          m_tw = 32'(q[p]);
          m_valid = ((p % (m_dwell + 1)) == 0);
        end
      end
      default: m_state = 0;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    chk("model", {28'd0, tw_out, tw_valid, busy, done, err},
        {28'd0, m_tw, m_valid, m_busy, m_done, m_err});
  endtask

  task automatic set_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                         input logic [15:0] dw, input logic md);
    cfg_start_tw = s; cfg_stop_tw = e; cfg_step = st; cfg_dwell = dw; cfg_mode = md;
  endtask

  // Assert reset between edges and check that the outputs clear without a clock.
  task automatic reset_mid();
    #2 reset = 1'b1;
    #1 chk("async_reset", {28'd0, tw_out, tw_valid, busy, done, err}, 64'd0);
    model_reset();
    @(negedge clk) reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit st, ab, pa, md;
    logic [31:0] s_tw, e_tw, stp;
    logic [15:0] dw;
    logic [31:0] x_tw;
    bit xv, xb, xd, xe;
  } vec_t;

  function automatic vec_t mk(bit st, bit ab, bit pa, bit md, logic [31:0] s, logic [31:0] e,
                              logic [31:0] stp, logic [15:0] dw, logic [31:0] x,
                              bit xv, bit xb, bit xd, bit xe);
    vec_t v;
    v.st = st; v.ab = ab; v.pa = pa; v.md = md; v.s_tw = s; v.e_tw = e; v.stp = stp;
    v.dw = dw; v.x_tw = x; v.xv = xv; v.xb = xb; v.xd = xd; v.xe = xe;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    int h[3];
    int vcount;
    bit seen;
    logic [31:0] exp37[6];
    logic [31:0] frozen;

    // Rejected starts, a start suppressed by abort, then a one-shot sweep
    // 100..130 step 10 dwell 2. The cfg inputs are scrambled after the start
    // is accepted, and a second start arrives while the sweep is running.
    tbl[0]  = mk(1,0,0,0, 100,130, 0,2,   0,0,0,0,1);
    tbl[1]  = mk(0,0,0,0, 100,130,10,2,   0,0,0,0,0);
    tbl[2]  = mk(1,0,0,0,  50, 40,10,2,   0,0,0,0,1);
    tbl[3]  = mk(0,0,0,0,  50, 40,10,2,   0,0,0,0,0);
    tbl[4]  = mk(1,1,0,0, 100,130,10,2,   0,0,0,0,0);
    tbl[5]  = mk(1,0,0,0, 100,130,10,2, 100,1,1,0,0);
    tbl[6]  = mk(0,0,0,1,   7,  9, 1,0, 100,0,1,0,0);
    tbl[7]  = mk(1,0,0,1,   7,  9, 1,0, 100,0,1,0,0);
    tbl[8]  = mk(0,0,0,1,   7,  9, 1,0, 110,1,1,0,0);
    tbl[9]  = mk(0,0,0,1,   7,  9, 1,0, 110,0,1,0,0);
    tbl[10] = mk(0,0,0,1,   7,  9, 1,0, 110,0,1,0,0);
    tbl[11] = mk(0,0,0,1,   7,  9, 1,0, 120,1,1,0,0);
    tbl[12] = mk(0,0,0,1,   7,  9, 1,0, 120,0,1,0,0);
    tbl[13] = mk(0,0,0,1,   7,  9, 1,0, 120,0,1,0,0);
    tbl[14] = mk(0,0,0,1,   7,  9, 1,0, 130,1,1,0,0);
    tbl[15] = mk(0,0,0,1,   7,  9, 1,0, 130,0,1,0,0);
    tbl[16] = mk(0,0,0,1,   7,  9, 1,0, 130,0,1,0,0);
    tbl[17] = mk(0,0,0,1,   7,  9, 1,0, 130,0,0,1,0);
    tbl[18] = mk(0,0,0,1,   7,  9, 1,0, 130,0,0,0,0);

    model_reset();
    repeat (2) @(posedge clk);
    #1 chk("reset_state", {28'd0, tw_out, tw_valid, busy, done, err}, 64'd0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      start = tbl[i].st; abort = tbl[i].ab; pause = tbl[i].pa;
      set_cfg(tbl[i].s_tw, tbl[i].e_tw, tbl[i].stp, tbl[i].dw, tbl[i].md);
      tick();
      chk($sformatf("vec%0d", i), {28'd0, tw_out, tw_valid, busy, done, err},
          {28'd0, tbl[i].x_tw, tbl[i].xv, tbl[i].xb, tbl[i].xd, tbl[i].xe});
    end

    // Repeating sweep with dwell 0, then abort freezes the word.
    exp37[0] = 100; exp37[1] = 110; exp37[2] = 120;
    exp37[3] = 100; exp37[4] = 110; exp37[5] = 120;
    set_cfg(100, 125, 10, 0, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      chk($sformatf("repeat_word%0d", i), {31'd0, tw_valid, tw_out}, {31'd1, exp37[i]});
    end
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_idle", {29'd0, tw_valid, busy, done, tw_out}, {29'd0, 3'b000, 32'd120});
    tick();
    chk("abort_frozen", {31'd0, busy, tw_out}, {31'd0, 1'b0, 32'd120});

    // A pause of 5 cycles in the middle of a dwell of 3 stretches that word to 9 cycles.
    set_cfg(100, 120, 10, 3, 1'b0);
    h[0] = 0; h[1] = 0; h[2] = 0; seen = 0;
    start = 1'b1; tick(); start = 1'b0;
    if (busy && tw_out >= 100 && tw_out <= 120) h[(tw_out - 100) / 10]++;
    tick();
    if (busy && tw_out >= 100 && tw_out <= 120) h[(tw_out - 100) / 10]++;
    pause = 1'b1;
    repeat (5) begin
      tick();
      if (busy && tw_out >= 100 && tw_out <= 120) h[(tw_out - 100) / 10]++;
    end
    pause = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (done) seen = 1;
      else if (busy && tw_out >= 100 && tw_out <= 120) h[(tw_out - 100) / 10]++;
    end
    chk("pause_done_seen", 64'(seen), 64'd1);
    chk("pause_hold100", 64'(h[0]), 64'd9);
    chk("pause_hold110", 64'(h[1]), 64'd4);
    chk("pause_hold120", 64'(h[2]), 64'd4);
    tick();

    // Overflow of start+step past the word width ends the sweep after one word.
    set_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 1, 1'b0);
    vcount = 0; seen = 0;
    start = 1'b1; tick(); start = 1'b0;
    if (tw_valid) vcount++;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (tw_valid) vcount++;
      if (done) seen = 1;
    end
    chk("ovf_done_seen", 64'(seen), 64'd1);
    chk("ovf_valid_count", 64'(vcount), 64'd1);
    chk("ovf_last_word", 64'(tw_out), 64'hFFFF_FFF0);
    tick();

    // Reset in the middle of a sweep, then a fresh start from a new start word.
    set_cfg(100, 130, 10, 1, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (tw_out == 32'd110) seen = 1;
    end
    chk("reach_110", 64'(seen), 64'd1);
    reset_mid();
    tick();
    chk("after_reset_idle", {31'd0, busy, tw_out}, 64'd0);
    set_cfg(200, 240, 20, 1, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_word", {31'd0, tw_valid, tw_out}, {31'd1, 32'd200});
    frozen = tw_out;
    tick();
    chk("restart_hold", 64'(tw_out), 64'(frozen));

    // Random stimulus checked against the model every cycle.
    for (int i = 0; i < 6000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      abort = ($urandom_range(0, 29) == 0);
      pause = ($urandom_range(0, 3) == 0);
      set_cfg($urandom_range(0, 1000), $urandom_range(0, 1200), $urandom_range(0, 60),
              16'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
